// File: rtl/ddr3_cmd_arb.sv
// ddr3_cmd_arb: two-port round-robin arbiter in front of the DDR3 controller local interface.
// Grants one whole transaction at a time and steers write handshakes and read beats to its owner.
module ddr3_cmd_arb #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        a_cmd_valid,
    input  logic [3:0]  a_cmd,
    input  logic [25:0] a_addr,
    input  logic [4:0]  a_burst_cnt,
    input  logic [63:0] a_write_data,
    input  logic [7:0]  a_data_mask,
    output logic        a_cmd_ack,
    output logic        a_wr_rdy,
    output logic [63:0] a_rd_data,
    output logic        a_rd_valid,

    input  logic        b_cmd_valid,
    input  logic [3:0]  b_cmd,
    input  logic [25:0] b_addr,
    input  logic [4:0]  b_burst_cnt,
    input  logic [63:0] b_write_data,
    input  logic [7:0]  b_data_mask,
    output logic        b_cmd_ack,
    output logic        b_wr_rdy,
    output logic [63:0] b_rd_data,
    output logic        b_rd_valid,

    input  logic        mc_init_done,
    input  logic        mc_cmd_rdy,
    input  logic        mc_datain_rdy,
    input  logic [63:0] mc_read_data,
    input  logic        mc_read_data_valid,
    output logic        mc_cmd_valid,
    output logic [3:0]  mc_cmd,
    output logic [25:0] mc_addr,
    output logic [4:0]  mc_burst_cnt,
    output logic [63:0] mc_write_data,
    output logic [7:0]  mc_data_mask,

    output logic        busy,
    output logic        owner,
    output logic        timeout_err
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWdata,
        StRdata
    } state_e;

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic [6:0]     beats_q, beats_d;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           timeout_q, timeout_d;

    logic [3:0]     own_cmd;
    logic [25:0]    own_addr;
    logic [4:0]     own_burst;
    logic           own_is_rd;
    logic           own_is_wr;
    logic           grant_port;
    logic [4:0]     grant_burst;
    logic           data_beat;

    function automatic logic is_read(input logic [3:0] code);
        return (code == 4'b0001) || (code == 4'b0011);
    endfunction

    function automatic logic is_write(input logic [3:0] code);
        return (code == 4'b0010) || (code == 4'b0100);
    endfunction

    // Burst count 0 encodes 32 bursts, i.e. 64 beats.
    function automatic logic [6:0] beats_for(input logic [4:0] bc);
        return (bc == 5'd0) ? 7'd64 : {1'b0, bc, 1'b0};
    endfunction

    always_comb begin
        own_cmd     = owner_q ? b_cmd       : a_cmd;
        own_addr    = owner_q ? b_addr      : a_addr;
        own_burst   = owner_q ? b_burst_cnt : a_burst_cnt;
        own_is_rd   = is_read(own_cmd);
        own_is_wr   = is_write(own_cmd);
        // On contention the port that did not hold the last grant wins.
        grant_port  = (a_cmd_valid && b_cmd_valid) ? ~owner_q : b_cmd_valid;
        grant_burst = grant_port ? b_burst_cnt : a_burst_cnt;
        data_beat   = ((state_q == StWdata) && mc_datain_rdy) ||
                      ((state_q == StRdata) && mc_read_data_valid);
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beats_d   = beats_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (mc_init_done && (a_cmd_valid || b_cmd_valid)) begin
                    state_d = StIssue;
                    owner_d = grant_port;
                    beats_d = beats_for(grant_burst);
                end
            end
            StIssue: begin
                if (mc_cmd_rdy) begin
                    wdog_d = '0;
                    if (own_is_wr) begin
                        state_d = StWdata;
                    end else if (own_is_rd) begin
                        state_d = StRdata;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWdata, StRdata: begin
                if (data_beat && (beats_q == 7'd1)) begin
                    state_d = StIdle;
                end else begin
                    if (data_beat) begin
                        beats_d = beats_q - 7'd1;
                    end
                    // A completing last beat takes priority over the watchdog.
                    if (wdog_q == WdW'(TIMEOUT - 1)) begin
                        state_d   = StIdle;
                        timeout_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mc_cmd_valid  = (state_q == StIssue);
        mc_cmd        = mc_cmd_valid ? own_cmd   : 4'd0;
        mc_addr       = mc_cmd_valid ? own_addr  : 26'd0;
        mc_burst_cnt  = mc_cmd_valid ? own_burst : 5'd0;
        mc_write_data = owner_q ? b_write_data : a_write_data;
        mc_data_mask  = owner_q ? b_data_mask  : a_data_mask;

        a_cmd_ack     = mc_cmd_valid && mc_cmd_rdy && !owner_q;
        b_cmd_ack     = mc_cmd_valid && mc_cmd_rdy &&  owner_q;
        a_wr_rdy      = (state_q == StWdata) && mc_datain_rdy && !owner_q;
        b_wr_rdy      = (state_q == StWdata) && mc_datain_rdy &&  owner_q;
        a_rd_data     = mc_read_data;
        b_rd_data     = mc_read_data;
        a_rd_valid    = (state_q == StRdata) && mc_read_data_valid && !owner_q;
        b_rd_valid    = (state_q == StRdata) && mc_read_data_valid &&  owner_q;

        busy          = (state_q != StIdle);
        owner         = owner_q;
        timeout_err   = timeout_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            owner_q   <= 1'b1;
            beats_q   <= 7'd0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            beats_q   <= beats_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_arb.sv
// Bench for ddr3_cmd_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_ddr3_cmd_arb;

    localparam int TB_TIMEOUT = 80;

    logic        clk;
    logic        rstn;
    logic        a_cmd_valid, b_cmd_valid;
    logic [3:0]  a_cmd, b_cmd;
    logic [25:0] a_addr, b_addr;
    logic [4:0]  a_burst_cnt, b_burst_cnt;
    logic [63:0] a_write_data, b_write_data;
    logic [7:0]  a_data_mask, b_data_mask;
    logic        a_cmd_ack, b_cmd_ack, a_wr_rdy, b_wr_rdy, a_rd_valid, b_rd_valid;
    logic [63:0] a_rd_data, b_rd_data;
    logic        mc_init_done, mc_cmd_rdy, mc_datain_rdy, mc_read_data_valid;
    logic [63:0] mc_read_data;
    logic        mc_cmd_valid;
    logic [3:0]  mc_cmd;
    logic [25:0] mc_addr;
    logic [4:0]  mc_burst_cnt;
    logic [63:0] mc_write_data;
    logic [7:0]  mc_data_mask;
    logic        busy, owner, timeout_err;

    int checks;
    int errors;

    // Reference model: one outstanding transaction, described by who owns it,
    // whether the controller accepted the command, and how many beats remain.
    bit m_active, m_accepted, m_is_rd, m_is_wr, m_owner, m_err, m_ack_a, m_ack_b;
    int m_port, m_left, m_wd;

    ddr3_cmd_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .a_cmd_valid(a_cmd_valid), .a_cmd(a_cmd), .a_addr(a_addr), .a_burst_cnt(a_burst_cnt),
        .a_write_data(a_write_data), .a_data_mask(a_data_mask), .a_cmd_ack(a_cmd_ack),
        .a_wr_rdy(a_wr_rdy), .a_rd_data(a_rd_data), .a_rd_valid(a_rd_valid),
        .b_cmd_valid(b_cmd_valid), .b_cmd(b_cmd), .b_addr(b_addr), .b_burst_cnt(b_burst_cnt),
        .b_write_data(b_write_data), .b_data_mask(b_data_mask), .b_cmd_ack(b_cmd_ack),
        .b_wr_rdy(b_wr_rdy), .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid),
        .mc_init_done(mc_init_done), .mc_cmd_rdy(mc_cmd_rdy), .mc_datain_rdy(mc_datain_rdy),
        .mc_read_data(mc_read_data), .mc_read_data_valid(mc_read_data_valid),
        .mc_cmd_valid(mc_cmd_valid), .mc_cmd(mc_cmd), .mc_addr(mc_addr),
        .mc_burst_cnt(mc_burst_cnt), .mc_write_data(mc_write_data),
        .mc_data_mask(mc_data_mask), .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic model_step();
        logic [3:0] code;
        int bc;
        m_ack_a = 1'b0;
        m_ack_b = 1'b0;
        if (!rstn) begin
            m_active = 1'b0;
            m_owner  = 1'b1;
            m_err    = 1'b0;
            return;
        end
        if (!m_active) begin
            if (mc_init_done && (a_cmd_valid || b_cmd_valid)) begin
                if (a_cmd_valid && b_cmd_valid) m_port = m_owner ? 0 : 1;
                else m_port = a_cmd_valid ? 0 : 1;
                m_owner    = (m_port == 1);
                code       = (m_port == 1) ? b_cmd : a_cmd;
                bc         = (m_port == 1) ? int'(b_burst_cnt) : int'(a_burst_cnt);
                m_is_rd    = code inside {4'b0001, 4'b0011};
                m_is_wr    = code inside {4'b0010, 4'b0100};
                m_left     = 2 * ((bc == 0) ? 32 : bc);
                m_active   = 1'b1;
                m_accepted = 1'b0;
            end
        end else if (!m_accepted) begin
            if (mc_cmd_rdy) begin
                if (m_port == 0) m_ack_a = 1'b1;
                else m_ack_b = 1'b1;
                if (m_is_rd || m_is_wr) begin
                    m_accepted = 1'b1;
                    m_wd       = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end else begin
            if (m_is_wr ? mc_datain_rdy : mc_read_data_valid) m_left--;
            m_wd++;
            if (m_left == 0) begin
                m_active = 1'b0;
            end else if (m_wd == TB_TIMEOUT) begin
                m_active = 1'b0;
                m_err    = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_cmd_valid = 1'b0; a_cmd = 4'd0; a_addr = 26'd0; a_burst_cnt = 5'd0;
        a_write_data = 64'd0; a_data_mask = 8'd0;
        b_cmd_valid = 1'b0; b_cmd = 4'd0; b_addr = 26'd0; b_burst_cnt = 5'd0;
        b_write_data = 64'd0; b_data_mask = 8'd0;
        mc_init_done = 1'b1; mc_cmd_rdy = 1'b0; mc_datain_rdy = 1'b0;
        mc_read_data = 64'd0; mc_read_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        mc_datain_rdy = 1'b1;
        mc_read_data_valid = 1'b1;
        rstn = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %0b want 0", busy);
        end
        checks++;
        if (owner !== 1'b1) begin
            errors++; $display("FAIL reset_owner got %0b want 1", owner);
        end
        checks++;
        if (mc_cmd_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got cmd_valid=%0b err=%0b want 0 0", mc_cmd_valid,
                     timeout_err);
        end
        checks++;
        if ({mc_cmd, mc_addr, mc_burst_cnt} !== 35'd0) begin
            errors++;
            $display("FAIL reset_fields got cmd=%h addr=%h bc=%h want 0", mc_cmd, mc_addr,
                     mc_burst_cnt);
        end
        checks++;
        if ({a_cmd_ack, b_cmd_ack, a_wr_rdy, b_wr_rdy, a_rd_valid, b_rd_valid} !== 6'd0) begin
            errors++;
            $display("FAIL reset_handshakes got %b want 000000",
                     {a_cmd_ack, b_cmd_ack, a_wr_rdy, b_wr_rdy, a_rd_valid, b_rd_valid});
        end
        rstn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_init_gating();
        do_reset();
        mc_init_done = 1'b0;
        a_cmd_valid = 1'b1; a_cmd = 4'b0010; a_addr = 26'h0000100; a_burst_cnt = 5'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            checks++;
            if (mc_cmd_valid !== 1'b0 || a_cmd_ack !== 1'b0) begin
                errors++;
                $display("FAIL init_hold cycle %0d got cmd_valid=%0b ack=%0b want 0 0", i,
                         mc_cmd_valid, a_cmd_ack);
            end
        end
        mc_init_done = 1'b1;
        tick();
        #1;
        checks++;
        if (mc_cmd_valid !== 1'b1 || mc_cmd !== 4'b0010) begin
            errors++;
            $display("FAIL init_release got cmd_valid=%0b cmd=%h want 1 2", mc_cmd_valid, mc_cmd);
        end
        do_reset();
    endtask

    task automatic test_single_write();
        int wr_cnt;
        do_reset();
        a_cmd_valid = 1'b1; a_cmd = 4'b0010; a_addr = 26'h0000100; a_burst_cnt = 5'd1;
        mc_cmd_rdy = 1'b1;
        tick();
        #1;
        checks++;
        if (a_cmd_ack !== 1'b1 || b_cmd_ack !== 1'b0 || mc_addr !== 26'h0000100 ||
            mc_burst_cnt !== 5'd1) begin
            errors++;
            $display("FAIL write_issue got ack_a=%0b ack_b=%0b addr=%h bc=%0d want 1 0 100 1",
                     a_cmd_ack, b_cmd_ack, mc_addr, mc_burst_cnt);
        end
        tick();
        a_cmd_valid = 1'b0;
        mc_cmd_rdy = 1'b0;
        mc_datain_rdy = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            a_write_data = {$urandom, $urandom};
            a_data_mask = 8'($urandom);
            #1;
            if (a_wr_rdy === 1'b1) wr_cnt++;
            checks++;
            if (mc_write_data !== a_write_data || mc_data_mask !== a_data_mask ||
                b_wr_rdy !== 1'b0 || a_cmd_ack !== 1'b0) begin
                errors++;
                $display("FAIL write_beat %0d got data=%h mask=%h b_rdy=%0b ack=%0b want %h %h 0 0",
                         i, mc_write_data, mc_data_mask, b_wr_rdy, a_cmd_ack, a_write_data,
                         a_data_mask);
            end
            tick();
        end
        #1;
        checks++;
        if (wr_cnt != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_done got beats=%0d busy=%0b want 2 0", wr_cnt, busy);
        end
        do_reset();
    endtask

    task automatic test_contention();
        int a_beats, b_beats, first;
        bit b_early, ack_a, ack_b;
        do_reset();
        a_cmd_valid = 1'b1; a_cmd = 4'b0001; a_burst_cnt = 5'd2; a_addr = 26'h12345;
        b_cmd_valid = 1'b1; b_cmd = 4'b0011; b_burst_cnt = 5'd2; b_addr = 26'h0abcd;
        mc_cmd_rdy = 1'b1;
        mc_read_data_valid = 1'b1;
        a_beats = 0; b_beats = 0; first = -1; b_early = 1'b0;
        for (int cyc = 0; cyc < 60 && !(a_beats == 4 && b_beats == 4); cyc++) begin
            mc_read_data = {$urandom, $urandom};
            #1;
            if (a_cmd_ack === 1'b1 && first < 0) first = 0;
            if (b_cmd_ack === 1'b1 && first < 0) first = 1;
            if (a_rd_valid === 1'b1) begin
                a_beats++;
                checks++;
                if (a_rd_data !== mc_read_data) begin
                    errors++;
                    $display("FAIL contention_rd_data got %h want %h", a_rd_data, mc_read_data);
                end
            end
            if (b_rd_valid === 1'b1) begin
                b_beats++;
                if (a_beats < 4) b_early = 1'b1;
            end
            ack_a = a_cmd_ack;
            ack_b = b_cmd_ack;
            tick();
            if (ack_a) a_cmd_valid = 1'b0;
            if (ack_b) b_cmd_valid = 1'b0;
        end
        checks++;
        if (first != 0) begin
            errors++; $display("FAIL contention_first got %0d want 0", first);
        end
        checks++;
        if (a_beats != 4 || b_beats != 4) begin
            errors++; $display("FAIL contention_beats got a=%0d b=%0d want 4 4", a_beats, b_beats);
        end
        checks++;
        if (b_early) begin
            errors++; $display("FAIL contention_b_during_a got 1 want 0");
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int seq[$];
        int a_left, b_left;
        bit ack_a, ack_b;
        do_reset();
        a_cmd = 4'b0110; b_cmd = 4'b0110;
        a_cmd_valid = 1'b1; b_cmd_valid = 1'b1;
        a_left = 3; b_left = 3;
        mc_cmd_rdy = 1'b1;
        for (int cyc = 0; cyc < 80 && seq.size() < 6; cyc++) begin
            #1;
            ack_a = a_cmd_ack;
            ack_b = b_cmd_ack;
            if (ack_a) seq.push_back(0);
            if (ack_b) seq.push_back(1);
            tick();
            if (ack_a) begin a_left--; a_cmd_valid = (a_left > 0); end
            if (ack_b) begin b_left--; b_cmd_valid = (b_left > 0); end
        end
        checks++;
        if (seq.size() != 6) begin
            errors++; $display("FAIL rr_count got %0d want 6", seq.size());
        end
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (seq[i] != (i % 2)) begin
                errors++; $display("FAIL rr_grant %0d got %0d want %0d", i, seq[i], i % 2);
            end
        end
        do_reset();
    endtask

    task automatic test_burst_zero();
        int beats;
        bit a_seen;
        do_reset();
        b_cmd_valid = 1'b1; b_cmd = 4'b0001; b_burst_cnt = 5'd0; b_addr = 26'h3ffffff;
        mc_cmd_rdy = 1'b1;
        mc_read_data_valid = 1'b1;
        tick();
        #1;
        checks++;
        if (b_cmd_ack !== 1'b1 || mc_burst_cnt !== 5'd0 || owner !== 1'b1) begin
            errors++;
            $display("FAIL bz_issue got ack=%0b bc=%0d owner=%0b want 1 0 1", b_cmd_ack,
                     mc_burst_cnt, owner);
        end
        tick();
        b_cmd_valid = 1'b0;
        beats = 0;
        a_seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (busy !== 1'b1) break;
            if (b_rd_valid === 1'b1) beats++;
            if (a_rd_valid === 1'b1) a_seen = 1'b1;
            tick();
        end
        checks++;
        if (beats != 64 || a_seen || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL bz_beats got beats=%0d a_seen=%0b busy=%0b err=%0b want 64 0 0 0",
                     beats, a_seen, busy, timeout_err);
        end
        do_reset();
    endtask

    task automatic test_watchdog();
        int cycles;
        do_reset();
        a_cmd_valid = 1'b1; a_cmd = 4'b0011; a_burst_cnt = 5'd1;
        mc_cmd_rdy = 1'b1;
        tick();
        tick();
        a_cmd_valid = 1'b0;
        cycles = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            #1;
            if (busy !== 1'b1) break;
            cycles++;
            tick();
        end
        checks++;
        if (cycles != TB_TIMEOUT || timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_expire got cycles=%0d err=%0b busy=%0b want %0d 1 0", cycles,
                     timeout_err, busy, TB_TIMEOUT);
        end
        mc_read_data_valid = 1'b1;
        tick();
        #1;
        checks++;
        if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_idle_discard got a=%0b b=%0b err=%0b want 0 0 1", a_rd_valid,
                     b_rd_valid, timeout_err);
        end
        mc_read_data_valid = 1'b0;
        a_cmd_valid = 1'b1; a_cmd = 4'b0100; a_burst_cnt = 5'd4;
        tick();
        tick();
        a_cmd_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || owner !== 1'b0) begin
            errors++; $display("FAIL wd_in_wdata got busy=%0b owner=%0b want 1 0", busy, owner);
        end
        mc_datain_rdy = 1'b1;
        rstn = 1'b0;
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || owner !== 1'b1 || mc_cmd_valid !== 1'b0 ||
            a_wr_rdy !== 1'b0 || a_cmd_ack !== 1'b0) begin
            errors++;
            $display("FAIL wd_reset got busy=%0b err=%0b owner=%0b cv=%0b wr=%0b ack=%0b want 0 0 1 0 0 0",
                     busy, timeout_err, owner, mc_cmd_valid, a_wr_rdy, a_cmd_ack);
        end
        rstn = 1'b1;
        do_reset();
    endtask

    task automatic test_random();
        bit e_issue, e_data;
        logic [34:0] e_fields;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (m_ack_a) a_cmd_valid = 1'b0;
            if (m_ack_b) b_cmd_valid = 1'b0;
            if (!a_cmd_valid && $urandom_range(3) == 0) begin
                a_cmd_valid = 1'b1; a_cmd = 4'($urandom_range(7));
                a_addr = 26'($urandom); a_burst_cnt = 5'($urandom_range(4));
            end
            if (!b_cmd_valid && $urandom_range(3) == 0) begin
                b_cmd_valid = 1'b1; b_cmd = 4'($urandom_range(7));
                b_addr = 26'($urandom); b_burst_cnt = 5'($urandom_range(4));
            end
            a_write_data = {$urandom, $urandom}; a_data_mask = 8'($urandom);
            b_write_data = {$urandom, $urandom}; b_data_mask = 8'($urandom);
            mc_init_done = ($urandom_range(7) != 0);
            mc_cmd_rdy = 1'($urandom_range(1));
            mc_datain_rdy = ($urandom_range(3) != 0);
            mc_read_data_valid = ($urandom_range(3) != 0);
            mc_read_data = {$urandom, $urandom};
            #1;
            e_issue = m_active && !m_accepted;
            e_data = m_active && m_accepted;
            e_fields = !e_issue ? 35'd0 : (m_port == 1) ? {b_cmd, b_addr, b_burst_cnt}
                                                         : {a_cmd, a_addr, a_burst_cnt};
            checks++;
            if (mc_cmd_valid !== e_issue || {mc_cmd, mc_addr, mc_burst_cnt} !== e_fields) begin
                errors++;
                $display("FAIL rnd_cmd cyc %0d got v=%0b f=%h want v=%0b f=%h", cyc, mc_cmd_valid,
                         {mc_cmd, mc_addr, mc_burst_cnt}, e_issue, e_fields);
            end
            checks++;
            if ({a_cmd_ack, b_cmd_ack} !== {e_issue && mc_cmd_rdy && m_port == 0,
                                            e_issue && mc_cmd_rdy && m_port == 1}) begin
                errors++;
                $display("FAIL rnd_ack cyc %0d got %b port=%0d issue=%0b", cyc,
                         {a_cmd_ack, b_cmd_ack}, m_port, e_issue);
            end
            checks++;
            if ({a_wr_rdy, b_wr_rdy} !== {e_data && m_is_wr && mc_datain_rdy && m_port == 0,
                                          e_data && m_is_wr && mc_datain_rdy && m_port == 1})
            begin
                errors++;
                $display("FAIL rnd_wr_rdy cyc %0d got %b port=%0d data=%0b wr=%0b", cyc,
                         {a_wr_rdy, b_wr_rdy}, m_port, e_data, m_is_wr);
            end
            checks++;
            if ({a_rd_valid, b_rd_valid} !==
                {e_data && m_is_rd && mc_read_data_valid && m_port == 0,
                 e_data && m_is_rd && mc_read_data_valid && m_port == 1} ||
                a_rd_data !== mc_read_data || b_rd_data !== mc_read_data) begin
                errors++;
                $display("FAIL rnd_rd cyc %0d got %b port=%0d data=%0b rd=%0b", cyc,
                         {a_rd_valid, b_rd_valid}, m_port, e_data, m_is_rd);
            end
            if (e_data && m_is_wr) begin
                checks++;
                if ({mc_write_data, mc_data_mask} !== ((m_port == 1) ?
                    {b_write_data, b_data_mask} : {a_write_data, a_data_mask})) begin
                    errors++;
                    $display("FAIL rnd_wdata cyc %0d got %h port=%0d", cyc, mc_write_data,
                             m_port);
                end
            end
            checks++;
            if (busy !== m_active || owner !== m_owner || timeout_err !== m_err) begin
                errors++;
                $display("FAIL rnd_status cyc %0d got busy=%0b own=%0b err=%0b want %0b %0b %0b",
                         cyc, busy, owner, timeout_err, m_active, m_owner, m_err);
            end
            tick();
        end
        do_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ack_a = 1'b0;
        m_ack_b = 1'b0;
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_init_gating();
        test_single_write();
        test_contention();
        test_round_robin();
        test_burst_zero();
        test_watchdog();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
